// File: rtl/hilo_muldiv_seq.sv
// HI/LO multiply/divide sequencer for the EX stage. It runs MULT/MULTU/DIV/DIVU
// as 32 iteration steps and serves MFHI/MFLO/MTHI/MTLO in a single cycle.
module hilo_muldiv_seq (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [5:0]  funct_i,
  input  logic [31:0] rs_val_i,
  input  logic [31:0] rt_val_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] mf_data_o
);
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MTHI = 6'b010001;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_MTLO = 6'b010011;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic [63:0] acc_q;
  logic [31:0] opnd_q, rs_raw_q, hi_q, lo_q;
  logic        div_q, sgn_diff_q, sgn_rs_q, busy_q;

  // funct 0110xx: bit1 selects divide, bit0 selects unsigned
  logic        is_md, is_div, is_signed, rs_neg, rt_neg;
  logic [31:0] rs_abs, rt_abs;
  assign is_md     = (funct_i[5:2] == 4'b0110);
  assign is_div    = funct_i[1];
  assign is_signed = ~funct_i[0];
  assign rs_neg    = is_signed & rs_val_i[31];
  assign rt_neg    = is_signed & rt_val_i[31];
  assign rs_abs    = rs_neg ? (~rs_val_i + 32'd1) : rs_val_i;
  assign rt_abs    = rt_neg ? (~rt_val_i + 32'd1) : rt_val_i;

  // Multiply: multiplier sits in acc[31:0] and shifts out as the product shifts in.
  logic [32:0] mul_sum;
  logic [63:0] mul_nxt;
  assign mul_sum = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
  assign mul_nxt = {mul_sum, acc_q[31:1]};

  // Divide: remainder in acc[63:32], dividend/quotient in acc[31:0].
  logic [32:0] div_cand, div_diff;
  logic        div_ge;
  logic [63:0] div_nxt;
  assign div_cand = {acc_q[63:32], acc_q[31]};
  assign div_diff = div_cand - {1'b0, opnd_q};
  assign div_ge   = (div_cand >= {1'b0, opnd_q});
  assign div_nxt  = div_ge ? {div_diff[31:0], acc_q[30:0], 1'b1}
                           : {div_cand[31:0], acc_q[30:0], 1'b0};

  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;
  assign prod_fix = sgn_diff_q ? (~acc_q + 64'd1) : acc_q;
  assign quo_fix  = sgn_diff_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign rem_fix  = sgn_rs_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      cnt_q      <= 6'd0;
      acc_q      <= 64'd0;
      opnd_q     <= 32'd0;
      rs_raw_q   <= 32'd0;
      div_q      <= 1'b0;
      sgn_diff_q <= 1'b0;
      sgn_rs_q   <= 1'b0;
      busy_q     <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          if (is_md) begin
            state_q    <= RUN;
            cnt_q      <= 6'd0;
            busy_q     <= 1'b1;
            div_q      <= is_div;
            sgn_diff_q <= rs_neg ^ rt_neg;
            sgn_rs_q   <= rs_neg;
            rs_raw_q   <= rs_val_i;
            opnd_q     <= is_div ? rt_abs : rs_abs;
            acc_q      <= {32'd0, (is_div ? rs_abs : rt_abs)};
          end else if (funct_i == F_MTHI) begin
            hi_q <= rs_val_i;
          end else if (funct_i == F_MTLO) begin
            lo_q <= rs_val_i;
          end
        end
        RUN: begin
          if (flush_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= div_q ? div_nxt : mul_nxt;
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == 6'd31) state_q <= FIX;
          end
        end
        FIX: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (!flush_i) begin
            if (!div_q) begin
              hi_q <= prod_fix[63:32];
              lo_q <= prod_fix[31:0];
            end else if (opnd_q == 32'd0) begin
              // divide by zero skips the sign fix-up entirely
              hi_q <= rs_raw_q;
              lo_q <= 32'hFFFF_FFFF;
            end else begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall_o   = ((state_q == RUN) | ((state_q == IDLE) & start_i & is_md)) & ~flush_i;
  assign busy_o    = busy_q;
  assign done_o    = (state_q == FIX) & ~flush_i;
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;
  assign mf_data_o = (start_i && funct_i == F_MFHI) ? hi_q :
                     (start_i && funct_i == F_MFLO) ? lo_q : 32'd0;
endmodule
